// File: rtl/hilo_muldiv.sv
// HI/LO multiply-divide unit: single-cycle MULT/MULTU/MTHI/MTLO and a
// 32-step restoring divider for DIV/DIVU, with a registered busy/done handshake.
module hilo_muldiv #(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        md_ena,
  input  logic        op_valid,
  input  logic [2:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int unsigned CW = (DIV_STEPS > 1) ? $clog2(DIV_STEPS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;
  typedef enum logic [2:0] {
    OP_NOP0  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_NOP7  = 3'd7
  } op_t;

  state_t          state_q, state_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     quo_q, quo_d;
  logic [31:0]     dvs_q, dvs_d;
  logic [31:0]     rem_q, rem_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;

  op_t             op_e;
  logic            accept;
  logic            is_signed;
  logic [31:0]     rs_abs, rt_abs;
  logic [63:0]     prod_s, prod_u;
  logic [32:0]     rem_sh;
  logic            step_ge;
  logic [31:0]     step_diff;

  always_comb begin
    op_e      = op_t'(op);
    accept    = md_ena && op_valid && !busy_q && (op_e != OP_NOP0) && (op_e != OP_NOP7);
    is_signed = (op_e == OP_DIV);
    // Two's-complement negation of 0x80000000 gives 0x80000000, which is the exact magnitude as unsigned.
    rs_abs    = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    rt_abs    = rt_data[31] ? (32'd0 - rt_data) : rt_data;
    prod_s    = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    prod_u    = {32'd0, rs_data} * {32'd0, rt_data};

    // Remainder stays below the divisor, so the subtraction result always fits 32 bits.
    rem_sh    = {rem_q, quo_q[31]};
    step_ge   = (rem_sh >= {1'b0, dvs_q});
    step_diff = rem_sh[31:0] - dvs_q;

    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;

    if (md_ena) begin
      unique case (state_q)
        S_IDLE: begin
          if (accept) begin
            unique case (op_e)
              OP_MULT: begin
                {hi_d, lo_d} = prod_s;
                done_d       = 1'b1;
              end
              OP_MULTU: begin
                {hi_d, lo_d} = prod_u;
                done_d       = 1'b1;
              end
              OP_DIV, OP_DIVU: begin
                if (rt_data == '0) begin
                  hi_d   = rs_data;
                  lo_d   = '1;
                  done_d = 1'b1;
                end else begin
                  quo_d   = is_signed ? rs_abs : rs_data;
                  dvs_d   = is_signed ? rt_abs : rt_data;
                  qneg_d  = is_signed && (rs_data[31] ^ rt_data[31]);
                  rneg_d  = is_signed && rs_data[31];
                  rem_d   = '0;
                  cnt_d   = '0;
                  busy_d  = 1'b1;
                  state_d = S_RUN;
                end
              end
              OP_MTHI: hi_d = rs_data;
              OP_MTLO: lo_d = rs_data;
              default: ;
            endcase
          end
        end
        S_RUN: begin
          // quo_q doubles as the dividend shifter: dividend bits leave the top as quotient bits enter the bottom.
          quo_d = {quo_q[30:0], step_ge};
          rem_d = step_ge ? step_diff : rem_sh[31:0];
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(DIV_STEPS - 1)) state_d = S_FIX;
        end
        S_FIX: begin
          lo_d    = qneg_q ? (32'd0 - quo_q) : quo_q;
          hi_d    = rneg_q ? (32'd0 - rem_q) : rem_q;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign hi_out = hi_q;
  assign lo_out = lo_q;

endmodule
